// File: rtl/fifo_frame_reader_pkg.sv
// ============================================================================
// Module  : fifo_frame_reader_pkg
// Brief   : Shared types and defaults for the audio FIFO frame reader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_frame_reader_pkg;

  localparam int c_DATA_WIDTH  = 24;
  localparam int c_FRAME_LEN   = 256;
  localparam int c_STATS_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fifo_frame_skid.sv
// ============================================================================
// Module  : fifo_frame_skid
// Brief   : Two-entry registered skid buffer; head entry drives the output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_frame_skid
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Clear_in,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) head_d = data_i;
        else               tail_d = data_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the arriving word queues behind any survivor.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = data_i;
        end else begin
          head_d = data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o = head_q;
  assign occ_o  = occ_q;

endmodule

`default_nettype wire

// File: rtl/fifo_frame_reader.sv
// ============================================================================
// Module  : fifo_frame_reader
// Brief   : Reads the audio sample FIFO and emits fixed-length frames on a
//           valid/ready stream. Define FIFO_FRAME_READER_STATS_EN for stats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int FRAME_LEN  = c_FRAME_LEN,
  parameter int FRAME_BITS = $clog2(FRAME_LEN)
) (
  input  logic                  Clk,
  input  logic                  Clear_in,
  input  logic                  Start_in,
  input  logic                  Continuous_in,
  input  logic [DATA_WIDTH-1:0] FifoData_in,
  input  logic                  FifoEmpty_in,
  output logic                  FifoReadEn_out,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Valid_out,
  input  logic                  Ready_in,
  output logic                  Sop_out,
  output logic                  Eop_out,
  output logic [FRAME_BITS-1:0] Index_out,
  output logic                  Busy_out
`ifdef FIFO_FRAME_READER_STATS_EN
  ,
  output logic [c_STATS_WIDTH-1:0] StallCount_out,
  output logic [c_STATS_WIDTH-1:0] FrameCount_out
`endif
);

  localparam logic [FRAME_BITS:0]   c_ISSUE_MAX = (FRAME_BITS+1)'(FRAME_LEN);
  localparam logic [FRAME_BITS-1:0] c_LAST_IDX  = FRAME_BITS'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS:0]   issued_q, issued_d;
  logic [FRAME_BITS-1:0] out_q, out_d;
  logic                  inflight_q;
  logic [1:0]            w_occ;
  logic                  w_room;
  logic                  w_xfer;
  logic                  w_eop_acc;

  fifo_frame_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .Clk      (Clk),
    .Clear_in (Clear_in),
    .push_i   (inflight_q),
    .data_i   (FifoData_in),
    .pop_i    (w_xfer),
    .data_o   (Data_out),
    .occ_o    (w_occ)
  );

  // Count words already granted but not yet accepted so the skid can never overflow.
  assign w_room    = (3'(w_occ) + 3'(inflight_q)) < 3'd2;
  assign w_xfer    = Valid_out & Ready_in;
  assign w_eop_acc = w_xfer & (out_q == c_LAST_IDX);

  assign FifoReadEn_out = ~Clear_in & (state_q == FILL) & ~FifoEmpty_in &
                          (issued_q < c_ISSUE_MAX) & w_room;

  assign Valid_out = (w_occ != 2'd0);
  assign Index_out = out_q;
  assign Sop_out   = Valid_out & (out_q == '0);
  assign Eop_out   = Valid_out & (out_q == c_LAST_IDX);
  assign Busy_out  = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    out_d    = out_q;
    if (FifoReadEn_out) issued_d = issued_q + 1'b1;
    if (w_xfer)         out_d    = out_q + 1'b1;
    case (state_q)
      IDLE:  if (Start_in) state_d = FILL;
      FILL:  if (issued_q == c_ISSUE_MAX) state_d = DRAIN;
      DRAIN: begin
        if (w_eop_acc) begin
          state_d  = Continuous_in ? FILL : IDLE;
          issued_d = '0;
          out_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      out_q      <= out_d;
      inflight_q <= FifoReadEn_out;
    end
  end

`ifdef FIFO_FRAME_READER_STATS_EN
  logic [c_STATS_WIDTH-1:0] stall_q;
  logic [c_STATS_WIDTH-1:0] frames_q;

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      stall_q  <= '0;
      frames_q <= '0;
    end else begin
      if ((state_q == FILL) && FifoEmpty_in && (issued_q < c_ISSUE_MAX) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (w_eop_acc)
        frames_q <= frames_q + 1'b1;
    end
  end

  assign StallCount_out = stall_q;
  assign FrameCount_out = frames_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// ============================================================================
// Module  : tb_fifo_frame_reader
// Brief   : Self-checking bench: queue-based FIFO and frame reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_frame_reader;
  import fifo_frame_reader_pkg::*;

  localparam int DW = 24;
  localparam int FL = 256;
  localparam int FB = 8;

  logic          Clk = 1'b0;
  logic          Clear_in = 1'b1;
  logic          Start_in = 1'b0;
  logic          Continuous_in = 1'b0;
  logic [DW-1:0] FifoData_in = '0;
  logic          FifoEmpty_in = 1'b1;
  logic          FifoReadEn_out;
  logic [DW-1:0] Data_out;
  logic          Valid_out;
  logic          Ready_in = 1'b1;
  logic          Sop_out;
  logic          Eop_out;
  logic [FB-1:0] Index_out;
  logic          Busy_out;
`ifdef FIFO_FRAME_READER_STATS_EN
  logic [15:0]   StallCount_out;
  logic [15:0]   FrameCount_out;
`endif

  always #5 Clk = ~Clk;

  fifo_frame_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .FRAME_BITS(FB)) dut (
    .Clk            (Clk),
    .Clear_in       (Clear_in),
    .Start_in       (Start_in),
    .Continuous_in  (Continuous_in),
    .FifoData_in    (FifoData_in),
    .FifoEmpty_in   (FifoEmpty_in),
    .FifoReadEn_out (FifoReadEn_out),
    .Data_out       (Data_out),
    .Valid_out      (Valid_out),
    .Ready_in       (Ready_in),
    .Sop_out        (Sop_out),
    .Eop_out        (Eop_out),
    .Index_out      (Index_out),
    .Busy_out       (Busy_out)
`ifdef FIFO_FRAME_READER_STATS_EN
    ,
    .StallCount_out (StallCount_out),
    .FrameCount_out (FrameCount_out)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: upstream FIFO contents, words owed downstream, frame progress.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit  force_empty = 0;
  bit  active = 0;
  int  g = 0, x = 0, frames = 0, stall = 0, cyc = 0, total_x = 0;
  int  first_rd = -1, first_val = -1;
  bit  last_rd = 0;
  logic [DW-1:0] last_xdata = '0;
  bit  prev_hold = 0;
  logic [DW+FB+2:0] prev_out = '0;
  int  rmode = 0;
  bit  emode = 0;

  typedef struct {
    logic clr;
    logic st;
    logic busy;
    logic valid;
    logic rden;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic upd_empty();
    FifoEmpty_in = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic tick();
    logic rd, xf, exp_rd, emp, clr, st, cont, a0;
    logic [DW+FB+2:0] cur;
    @(negedge Clk);
    emp = FifoEmpty_in; clr = Clear_in; st = Start_in; cont = Continuous_in;
    rd = FifoReadEn_out; xf = Valid_out & Ready_in; a0 = active;
    exp_rd = !clr && active && !emp && (g < FL) && ((g - x) < 2);
    chk("rden", rd, exp_rd);
    chk("busy", Busy_out, active);
`ifdef FIFO_FRAME_READER_STATS_EN
    chk("stallcount", StallCount_out, stall);
    chk("framecount", FrameCount_out, frames % 65536);
`endif
    cur = {Valid_out, Sop_out, Eop_out, Index_out, Data_out};
    if (prev_hold) chk("hold_stable", cur, prev_out);
    if (Valid_out) begin
      chk("index", Index_out, x);
      chk("sop", Sop_out, x == 0);
      chk("eop", Eop_out, x == FL - 1);
      if (first_val < 0) first_val = cyc;
    end
    if (xf) begin
      last_xdata = Data_out;
      if (exp_q.size() == 0) chk("spurious_xfer", 1, 0);
      else chk("data", Data_out, exp_q.pop_front());
    end
    if (rd && first_rd < 0) first_rd = cyc;
    prev_hold = Valid_out & !Ready_in;
    prev_out  = cur;
    @(posedge Clk);
    #1;
    last_rd = rd;
    if (clr) begin
      active = 0; g = 0; x = 0; stall = 0; frames = 0;
      exp_q.delete();
      prev_hold = 0;
      FifoData_in = DW'($urandom);
    end else begin
      if (active && g < FL && emp && stall < 65535) stall++;
      if (rd && fifo_q.size() > 0) begin
        g++;
        FifoData_in = fifo_q.pop_front();
        exp_q.push_back(FifoData_in);
      end else begin
        FifoData_in = DW'($urandom);
      end
      if (xf) begin
        x++; total_x++;
        if (x == FL) begin
          frames++; g = 0; x = 0;
          if (!cont) active = 0;
        end
      end
      if (!a0 && st) active = 1;
    end
    upd_empty();
    cyc++;
  endtask

  task automatic preload(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : DW'(base + i));
    upd_empty();
  endtask

  task automatic do_clear();
    Clear_in = 1'b1; tick(); Clear_in = 1'b0;
    fifo_q.delete(); force_empty = 0; upd_empty();
    total_x = 0; first_rd = -1; first_val = -1;
  endtask

  task automatic start_frame();
    Start_in = 1'b1; tick(); Start_in = 1'b0;
  endtask

  task automatic run_frame(input int bound, input string name);
    int n = 0;
    while (active && n < bound) begin
      if (rmode == 1) Ready_in = ~Ready_in;
      else if (rmode == 2) Ready_in = 1'($urandom_range(0, 1));
      if (emode) begin force_empty = ($urandom_range(0, 3) == 0); upd_empty(); end
      tick(); n++;
    end
    force_empty = 0; upd_empty(); Ready_in = 1'b1;
    chk({name, "_completed"}, active, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [DW-1:0] nxt;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge Clk);
    #1;
    // Reset / start / clear-priority table with the FIFO empty
    for (int i = 0; i < 7; i++) begin
      Clear_in = vecs[i].clr; Start_in = vecs[i].st;
      tick();
      #1;
      chk($sformatf("vec%0d_busy", i),  Busy_out,       vecs[i].busy);
      chk($sformatf("vec%0d_valid", i), Valid_out,      vecs[i].valid);
      chk($sformatf("vec%0d_rden", i),  FifoReadEn_out, vecs[i].rden);
      chk($sformatf("vec%0d_index", i), Index_out,      0);
    end
    Clear_in = 1'b0; Start_in = 1'b0;

    // Straight frame 0..255 with latency measurement
    do_clear(); preload(FL, 0, 0); Ready_in = 1'b1;
    start_frame(); run_frame(3000, "t1");
    chk("t1_count", total_x, FL);
    chk("t1_latency", first_val - first_rd, 2);
    chk("t1_busy_low", Busy_out, 0);

    // Backpressure toggling
    do_clear(); preload(FL, 1, 0); rmode = 1;
    start_frame(); run_frame(5000, "t2"); rmode = 0;
    chk("t2_count", total_x, FL);

    // FIFO empty for 10 cycles at sample 100
    do_clear(); preload(FL, 0, 5000);
    start_frame();
    n = 0;
    while (g < 100 && n < 1000) begin tick(); n++; end
    chk("t3_reach100", g, 100);
    force_empty = 1; upd_empty();
    repeat (10) tick();
    force_empty = 0; upd_empty();
    run_frame(3000, "t3");
    chk("t3_count", total_x, FL);
`ifdef FIFO_FRAME_READER_STATS_EN
    chk("t3_stallcount", StallCount_out, 10);
`endif

    // Continuous mode: two back-to-back frames
    do_clear(); preload(2 * FL, 0, 20000); Continuous_in = 1'b1;
    start_frame();
    n = 0;
    while (frames < 1 && n < 3000) begin tick(); n++; end
    Continuous_in = 1'b0;
    run_frame(3000, "t4");
    chk("t4_count", total_x, 2 * FL);
    chk("t4_frames", frames, 2);
`ifdef FIFO_FRAME_READER_STATS_EN
    chk("t4_framecount", FrameCount_out, 2);
`endif

    // Clear mid-frame with a word in flight
    do_clear(); preload(2 * FL, 0, 40000);
    start_frame();
    n = 0;
    while (!(x >= 50 && last_rd) && n < 1000) begin tick(); n++; end
    chk("t5_inflight_reached", last_rd, 1);
    Clear_in = 1'b1; tick(); Clear_in = 1'b0;
    #1;
    chk("t5_valid", Valid_out, 0);
    chk("t5_busy", Busy_out, 0);
    chk("t5_index", Index_out, 0);
    nxt = fifo_q[0];
    total_x = 0;
    start_frame();
    n = 0;
    while (total_x == 0 && n < 100) begin tick(); n++; end
    chk("t5_first_word", last_xdata, nxt);
    run_frame(3000, "t5");

    // Randomized ready and empty
    do_clear(); preload(FL, 1, 0); rmode = 2; emode = 1;
    start_frame(); run_frame(20000, "t6"); rmode = 0; emode = 0;
    chk("t6_count", total_x, FL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
